// File: rtl/spi_master.sv
// SPI initiator: serialises one word per wr pulse on sck/mosi/ss and captures miso
// into bus_out, with programmable sck divider, CPOL/CPHA and rdy/rdy_ack handshake.
module spi_master #(
    parameter int MAX_BITS_PER_WORD = 8,
    parameter int DIV_WIDTH         = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en_i,
    input  logic [1:0]                   mode_i,
    input  logic [DIV_WIDTH-1:0]         clk_div_i,
    input  logic [3:0]                   bit_per_word_i,
    input  logic                         lsb_first_i,
    input  logic                         hold_ss_i,
    input  logic [MAX_BITS_PER_WORD-1:0] bus_in_i,
    input  logic                         wr_i,
    output logic                         busy_o,
    output logic [MAX_BITS_PER_WORD-1:0] bus_out_o,
    output logic                         rdy_o,
    input  logic                         rdy_ack_i,
    output logic                         overrun_o,
    output logic                         sck_o,
    output logic                         mosi_o,
    output logic                         ss_o,
    input  logic                         miso_i
);

    localparam int         MB    = MAX_BITS_PER_WORD;
    localparam logic [4:0] MAX_N = 5'(MAX_BITS_PER_WORD);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        SHIFT = 2'd2,
        TRAIL = 2'd3
    } state_t;

    // Effective word length: 0 or anything above the bus width means a full word.
    function automatic logic [4:0] word_len(input logic [3:0] bpw);
        if (bpw == 4'd0 || {1'b0, bpw} > MAX_N) begin
            return MAX_N;
        end else begin
            return {1'b0, bpw};
        end
    endfunction

    // Bus position of the idx-th bit on the wire.
    function automatic logic [4:0] bit_pos(input logic [4:0] idx, input logic [4:0] n,
                                           input logic lsb);
        if (lsb) begin
            return idx;
        end else begin
            return n - 5'd1 - idx;
        end
    endfunction

    function automatic logic word_bit(input logic [MB-1:0] w, input logic [4:0] pos);
        logic [MB-1:0] sh;
        sh = w >> pos;
        return sh[0];
    endfunction

    state_t               state_q, state_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [5:0]           half_q, half_d;
    logic [4:0]           n_q, n_d;
    logic                 cpol_q, cpol_d;
    logic                 cpha_q, cpha_d;
    logic                 lsb_q, lsb_d;
    logic [MB-1:0]        tx_q, tx_d;
    logic [MB-1:0]        rx_q, rx_d;
    logic [MB-1:0]        bus_out_q, bus_out_d;
    logic                 sck_q, sck_d;
    logic                 mosi_q, mosi_d;
    logic                 ss_q, ss_d;
    logic                 busy_q, busy_d;
    logic                 rdy_q, rdy_d;
    logic                 ovr_q, ovr_d;

    logic                 phase_end_s;
    logic [DIV_WIDTH-1:0] cnt_next_s;
    logic                 last_half_s;
    logic [4:0]           samp_idx_s;
    logic [4:0]           drive_idx_s;
    logic [4:0]           n_new_s;
    logic                 complete_s;

    // Each half-period is H = div+1 cycles: the counter reloads at zero and never wraps.
    assign phase_end_s = (cnt_q == {DIV_WIDTH{1'b0}});
    assign cnt_next_s  = phase_end_s ? div_q : cnt_q - DIV_WIDTH'(1);
    assign last_half_s = (half_q == ({1'b0, n_q, 1'b0} - 6'd1));
    assign samp_idx_s  = half_q[5:1];
    assign drive_idx_s = cpha_q ? samp_idx_s : samp_idx_s + 5'd1;
    assign n_new_s     = word_len(bit_per_word_i);

    // Next-state, pin and completion logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        half_d     = half_q;
        n_d        = n_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        lsb_d      = lsb_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        sck_d      = sck_q;
        mosi_d     = mosi_q;
        ss_d       = ss_q;
        busy_d     = busy_q;
        complete_s = 1'b0;

        if (!en_i) begin
            state_d = IDLE;
            ss_d    = 1'b1;
            sck_d   = mode_i[1];
            mosi_d  = 1'b1;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    sck_d = mode_i[1];
                    if (wr_i) begin
                        n_d    = n_new_s;
                        cpol_d = mode_i[1];
                        cpha_d = mode_i[0];
                        lsb_d  = lsb_first_i;
                        div_d  = clk_div_i;
                        cnt_d  = clk_div_i;
                        tx_d   = bus_in_i;
                        rx_d   = {MB{1'b0}};
                        half_d = 6'd0;
                        busy_d = 1'b1;
                        ss_d   = 1'b0;
                        // CPHA=0 presents the first bit before the first sck edge.
                        mosi_d = mode_i[0] ? 1'b1
                                           : word_bit(bus_in_i, bit_pos(5'd0, n_new_s, lsb_first_i));
                        state_d = ss_q ? LEAD : SHIFT;
                    end else if (!hold_ss_i) begin
                        ss_d = 1'b1;
                    end else begin
                        ss_d = ss_q;
                    end
                end
                LEAD: begin
                    cnt_d = cnt_next_s;
                    if (phase_end_s) begin
                        state_d = SHIFT;
                    end else begin
                        state_d = LEAD;
                    end
                end
                SHIFT: begin
                    cnt_d = cnt_next_s;
                    if (phase_end_s) begin
                        sck_d = ~sck_q;
                        // Even half-periods end in a leading edge, odd ones in a trailing edge.
                        if (half_q[0] == cpha_q) begin
                            rx_d = rx_q | ({{(MB-1){1'b0}}, miso_i} << bit_pos(samp_idx_s, n_q, lsb_q));
                        end else if (!last_half_s) begin
                            mosi_d = word_bit(tx_q, bit_pos(drive_idx_s, n_q, lsb_q));
                        end else begin
                            mosi_d = mosi_q;
                        end
                        if (last_half_s) begin
                            state_d = TRAIL;
                        end else begin
                            half_d = half_q + 6'd1;
                        end
                    end else begin
                        state_d = SHIFT;
                    end
                end
                TRAIL: begin
                    cnt_d = cnt_next_s;
                    if (phase_end_s) begin
                        state_d    = IDLE;
                        busy_d     = 1'b0;
                        ss_d       = ~hold_ss_i;
                        mosi_d     = 1'b1;
                        complete_s = 1'b1;
                    end else begin
                        state_d = TRAIL;
                    end
                end
                default: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    ss_d    = 1'b1;
                end
            endcase
        end
    end

    // Completion handshake: a fresh word beats a same-cycle acknowledge.
    always_comb begin
        bus_out_d = bus_out_q;
        rdy_d     = rdy_q;
        ovr_d     = ovr_q;
        if (complete_s) begin
            bus_out_d = rx_q;
            rdy_d     = 1'b1;
            ovr_d     = (ovr_q | rdy_q) & ~rdy_ack_i;
        end else if (rdy_ack_i) begin
            rdy_d = 1'b0;
            ovr_d = 1'b0;
        end else begin
            rdy_d = rdy_q;
            ovr_d = ovr_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= {DIV_WIDTH{1'b0}};
            div_q     <= {DIV_WIDTH{1'b0}};
            half_q    <= 6'd0;
            n_q       <= MAX_N;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            lsb_q     <= 1'b0;
            tx_q      <= {MB{1'b0}};
            rx_q      <= {MB{1'b0}};
            bus_out_q <= {MB{1'b0}};
            sck_q     <= 1'b0;
            mosi_q    <= 1'b1;
            ss_q      <= 1'b1;
            busy_q    <= 1'b0;
            rdy_q     <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            half_q    <= half_d;
            n_q       <= n_d;
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
            lsb_q     <= lsb_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            bus_out_q <= bus_out_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            ss_q      <= ss_d;
            busy_q    <= busy_d;
            rdy_q     <= rdy_d;
            ovr_q     <= ovr_d;
        end
    end

    assign busy_o    = busy_q;
    assign bus_out_o = bus_out_q;
    assign rdy_o     = rdy_q;
    assign overrun_o = ovr_q;
    assign sck_o     = sck_q;
    assign mosi_o    = mosi_q;
    assign ss_o      = ss_q;

endmodule
